// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: queues {op, rs1, rs2, rd} instructions and steps
// each through READ -> EXEC -> WRITE against an external register file and ALU.
module alu_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2,
  output logic [1:0]            alu_sel,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           retired_count
);
  localparam int PW = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
  } instr_t;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  instr_t                r_mem [QUEUE_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [PW:0]           r_occ;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr1, r_rd_addr2;
  logic [1:0]            r_alu_sel;
  logic [DATA_WIDTH-1:0] r_alu_a, r_alu_b;
  logic                  r_wr_en, r_done;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [15:0]           r_retired;

  instr_t                w_in, w_head;
  logic                  w_push, w_pop;
  logic [PW:0]           w_occ_nxt;

  assign w_in        = '{op: instr_op, rs1: instr_rs1, rs2: instr_rs2, rd: instr_rd};
  assign w_head      = r_mem[r_rptr];
  assign instr_ready = r_occ < (PW+1)'(QUEUE_DEPTH);
  assign w_push      = instr_valid & instr_ready;
  assign w_pop       = (r_state == WRITE);
  assign w_occ_nxt   = r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);

  // Read addresses follow the head live in READ so an entry pushed on the
  // same edge that re-enters READ is picked up without a bypass path.
  assign rf_rd_addr1   = (r_state == READ) ? w_head.rs1 : r_rd_addr1;
  assign rf_rd_addr2   = (r_state == READ) ? w_head.rs2 : r_rd_addr2;
  assign alu_sel       = r_alu_sel;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign rf_wr_en      = r_wr_en;
  assign rf_wr_addr    = r_wr_addr;
  assign rf_wr_data    = r_wr_data;
  assign done          = r_done;
  assign retired_count = r_retired;
  assign busy          = (r_state != IDLE) || (r_occ != '0);

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wptr] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_rd_addr1 <= '0;
      r_rd_addr2 <= '0;
      r_alu_sel  <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_retired  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_occ <= w_occ_nxt;
      case (r_state)
        IDLE: if (r_occ != '0) r_state <= READ;
        READ: begin
          r_rd_addr1 <= w_head.rs1;
          r_rd_addr2 <= w_head.rs2;
          r_alu_a    <= rf_rd_data1;
          r_alu_b    <= rf_rd_data2;
          r_alu_sel  <= w_head.op;
          r_state    <= EXEC;
        end
        EXEC: begin
          r_wr_data <= alu_result;
          r_wr_addr <= w_head.rd;
          r_wr_en   <= 1'b1;
          r_done    <= 1'b1;
          r_state   <= WRITE;
        end
        WRITE: begin
          r_wr_en   <= 1'b0;
          r_done    <= 1'b0;
          r_retired <= r_retired + 16'd1;
          r_state   <= (w_occ_nxt != '0) ? READ : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width.
REQ-003 Parameter QUEUE_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 instr_valid  input  1  instruction offered.
REQ-007 instr_ready  output  1  queue can accept.
REQ-008 instr_op  input  2  0=add, 1=sub, 2=AND, 3=OR.
REQ-009 instr_rs1, instr_rs2, instr_rd  input  ADDR_WIDTH each  source/destination register addresses.
REQ-010 rf_rd_addr1, rf_rd_addr2  output  ADDR_WIDTH each  register file read addresses.
REQ-011 rf_rd_data1, rf_rd_data2  input  DATA_WIDTH each  combinational register file read data.
REQ-012 alu_sel  output  2  ALU operation select.
REQ-013 alu_a, alu_b  output  DATA_WIDTH each  registered ALU operands.
REQ-014 alu_result  input  DATA_WIDTH  combinational ALU result.
REQ-015 rf_wr_en, rf_wr_addr, rf_wr_data  output  1/ADDR_WIDTH/DATA_WIDTH  register file write port.
REQ-016 busy  output  1  FSM not IDLE or queue non-empty.
REQ-017 done  output  1  one-cycle pulse per retired instruction.
REQ-018 retired_count  output  16  retired instruction count.

Function
REQ-019 Queue: FIFO of {op, rs1, rs2, rd}; push on edge with instr_valid & instr_ready; instr_ready = (occupancy < QUEUE_DEPTH), combinational from registered occupancy only.
REQ-020 Full: instr_ready low, offered instruction held by source, no overwrite; push and pop on same edge leave occupancy unchanged.
REQ-021 Pointers wrap modulo QUEUE_DEPTH; occupancy tracked 0..QUEUE_DEPTH inclusive.
REQ-022 FSM states IDLE, READ, EXEC, WRITE; IDLE->READ when queue non-empty at the edge; READ->EXEC and EXEC->WRITE unconditional; WRITE->READ if occupancy after pop >0 (incl. same-edge push), else IDLE.
REQ-023 READ: rf_rd_addr1/2 = head rs1/rs2; rf_rd_data1/2 captured into alu_a/alu_b at exit edge; head op captured into alu_sel.
REQ-024 EXEC: alu_a/b/alu_sel stable; alu_result captured into rf_wr_data at exit edge, head rd into rf_wr_addr.
REQ-025 WRITE: rf_wr_en=1 and done=1 exactly this cycle; head popped and retired_count incremented at exit edge.
REQ-026 Latency: instruction pushed at edge E0 into empty idle block -> READ after E1, EXEC after E2, rf_wr_en/done high in cycle after E3.
REQ-027 Throughput: back-to-back queued instructions retire every 3 cycles, no IDLE gap.
REQ-028 Writes to any address including 0 issued as-is; no bypass/hazard logic (ordering guarantees RAW correctness since WRITE precedes next READ).
REQ-029 rf_rd_addr1/2 hold last driven value outside READ; rf_wr_en=0 outside WRITE.
REQ-030 Arithmetic is external; sub is alu_a minus alu_b modulo 2^DATA_WIDTH.
REQ-031 retired_count wraps 0xFFFF->0x0000.

Reset
REQ-032 rst_n low at an edge: state IDLE, queue emptied, all outputs 0 (instr_ready=1 from next cycle), retired_count=0.
REQ-033 Reset mid-instruction discards it; no rf_wr_en, no done; instruction presented during reset not accepted.

Verification
REQ-034 Single add: rs1=10 (data 7), rs2=5 (data 9), rd=6, op=0 -> rf_wr_en cycle after E3, rf_wr_addr=6, rf_wr_data=16, done 1 cycle, count=1.
REQ-035 Back-to-back sub (24:50-12:8->1), AND (28:0xF0 & 19:0x3C->8), OR (17:0x01 | 29:0x80->30) -> writes 42, 0x30, 0x81 at cycles 3 apart, in order.
REQ-036 Fill: 5 instructions offered with stalled start -> instr_ready low after 4 pushes; 5th accepted the edge after first pop; all 5 retire in order.
REQ-037 RAW: add r6=r10+r5 then sub r7=r6-r5 -> second result uses written r6 (16-9=7).
REQ-038 Reset asserted in EXEC -> no write, busy=0, instr_ready=1, count=0 after release; next instruction runs normally.
